// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath strobes from the state and the latched instruction fields.
module multicycle_control #(
    parameter bit ENABLE_MULDIV = 1'b1,
    parameter int WAIT_W        = 4,
    parameter int WAIT_LIMIT    = 15
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_0,
    input  logic       i_mem_ready,
    input  logic       d_mem_ready,
    input  logic       branch_taken,
    input  logic       muldiv_done,
    output logic [2:0] state,
    output logic       I_MEM_REQ,
    output logic       IRWrite,
    output logic       D_MEM_REQ,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic [6:0] ALUOp,
    output logic       ALUSrc1,
    output logic [1:0] ALUSrc2,
    output logic       MemtoReg,
    output logic [3:0] BE,
    output logic       muldiv_start,
    output logic [1:0] trap_cause
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_MULDIV = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_IMEM    = 2'b10,
        CAUSE_DMEM    = 2'b11
    } cause_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [WAIT_W-1:0] LIMIT      = WAIT_W'(WAIT_LIMIT);
    localparam bit                TIMEOUT_EN = (WAIT_LIMIT != 0);

    state_t            cur_state;
    state_t            nxt_state;
    cause_t            cause_q;
    cause_t            cause_nxt;
    logic [6:0]        op_q;
    // Only the access-size bits of funct3 matter after DECODE; funct7_0 is consumed in DECODE.
    logic [1:0]        size_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              legal_live;
    logic              muldiv_live;
    logic              wait_expired;
    logic              ready_sel;
    logic              is_load_q;
    logic              is_store_q;

    assign muldiv_live  = ENABLE_MULDIV && (opcode == OP_REG) && funct7_0;
    assign wait_expired = TIMEOUT_EN && (wait_cnt == LIMIT);
    assign ready_sel    = (cur_state == S_FETCH) ? i_mem_ready : d_mem_ready;
    assign is_load_q    = (op_q == OP_LOAD);
    assign is_store_q   = (op_q == OP_STORE);
    assign state        = cur_state;

    always_comb begin
        legal_live = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM: legal_live = 1'b1;
            OP_REG:    legal_live = !funct7_0 || ENABLE_MULDIV;
            OP_LOAD:   legal_live = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            OP_STORE:  legal_live = funct3 inside {3'b000, 3'b001, 3'b010};
            OP_BRANCH: legal_live = !(funct3 inside {3'b010, 3'b011});
            default:   legal_live = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            op_q     <= '0;
            size_q   <= '0;
            cause_q  <= CAUSE_NONE;
            wait_cnt <= '0;
        end else begin
            if (cur_state == S_DECODE) begin
                op_q   <= opcode;
                size_q <= funct3[1:0];
            end
            if (nxt_state == S_TRAP && cur_state != S_TRAP) begin
                cause_q <= cause_nxt;
            end
            // Cleared on any state change so each FETCH/MEM visit starts from zero.
            if (nxt_state != cur_state) begin
                wait_cnt <= '0;
            end else if ((cur_state == S_FETCH || cur_state == S_MEM) && !ready_sel
                         && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default before the case so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt_state = cur_state;
        cause_nxt = cause_q;
        case (cur_state)
            S_IDLE: nxt_state = S_FETCH;
            S_FETCH: begin
                if (i_mem_ready) begin
                    nxt_state = S_DECODE;
                end else if (wait_expired) begin
                    nxt_state = S_TRAP;
                    cause_nxt = CAUSE_IMEM;
                end
            end
            S_DECODE: begin
                if (!legal_live) begin
                    nxt_state = S_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else if (muldiv_live) begin
                    nxt_state = S_MULDIV;
                end else begin
                    nxt_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_BRANCH) begin
                    nxt_state = S_FETCH;
                end else if (is_load_q || is_store_q) begin
                    nxt_state = S_MEM;
                end else begin
                    nxt_state = S_WB;
                end
            end
            S_MEM: begin
                if (d_mem_ready) begin
                    nxt_state = is_store_q ? S_FETCH : S_WB;
                end else if (wait_expired) begin
                    nxt_state = S_TRAP;
                    cause_nxt = CAUSE_DMEM;
                end
            end
            S_MULDIV: if (muldiv_done) nxt_state = S_WB;
            S_WB:     nxt_state = S_FETCH;
            S_TRAP:   nxt_state = S_TRAP;
            default:  nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        I_MEM_REQ    = 1'b0;
        IRWrite      = 1'b0;
        D_MEM_REQ    = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        PCWrite      = 1'b0;
        PCSrc        = 2'b00;
        ALUOp        = (cur_state == S_IDLE) ? 7'd0 : op_q;
        ALUSrc1      = 1'b0;
        ALUSrc2      = 2'b00;
        MemtoReg     = 1'b0;
        BE           = 4'b0000;
        muldiv_start = 1'b0;
        trap_cause   = 2'b00;
        case (cur_state)
            S_FETCH: begin
                I_MEM_REQ = 1'b1;
                IRWrite   = i_mem_ready;
            end
            S_DECODE: muldiv_start = muldiv_live;
            S_EXEC: begin
                case (op_q)
                    OP_IMM, OP_LOAD, OP_STORE: ALUSrc2 = 2'b01;
                    OP_LUI, OP_AUIPC: begin
                        ALUSrc1 = 1'b1;
                        ALUSrc2 = 2'b01;
                    end
                    OP_JAL, OP_JALR: begin
                        ALUSrc1 = 1'b1;
                        ALUSrc2 = 2'b10;
                    end
                    default: ALUSrc2 = 2'b00;
                endcase
                if (op_q == OP_BRANCH) begin
                    PCWrite = 1'b1;
                    PCSrc   = branch_taken ? 2'b01 : 2'b00;
                end
            end
            S_MEM: begin
                D_MEM_REQ = 1'b1;
                MemWrite  = is_store_q;
                case (size_q)
                    2'b00:   BE = 4'b0001;
                    2'b01:   BE = 4'b0011;
                    default: BE = 4'b1111;
                endcase
                // A store retires on its ready cycle; loads retire in WB.
                PCWrite = is_store_q && d_mem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                MemtoReg = is_load_q;
                if (op_q == OP_JAL) begin
                    PCSrc = 2'b01;
                end else if (op_q == OP_JALR) begin
                    PCSrc = 2'b10;
                end
            end
            S_TRAP:  trap_cause = cause_q;
            default: ALUSrc2 = 2'b00;
        endcase
    end

endmodule
